fetch_ifid_stage: RTL and testbench

Fetch stage plus IF/ID pipeline register of the 16-bit, 5-stage pipeline. It is the consumer of the hazard unit's stall_mem/stall_br outputs. Owns the PC, drives the instruction-memory address, and applies the following to the IF/ID latch:
- hazard stalls
- branch redirects from ID
- instruction-memory miss stalls
- HLT detection
Feeds decode with instruction, PC+2 and a valid bit.

---
 rtl/fetch_ifid_stage.sv | 111 +++++++++++
 tb/tb_fetch_ifid_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_ifid_stage.sv
// Fetch stage and IF/ID pipeline register: owns the PC, applies hazard holds,
// branch redirects, instruction-memory miss bubbles and HLT freeze.
module fetch_ifid_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] NOP_INSTR   = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_mem,
  input  logic        stall_br,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic [15:0] imem_addr,
  output logic [15:0] instr_FD,
  output logic [15:0] pcPlus2_FD,
  output logic        valid_FD,
  output logic        halt_FD,
  output logic        halted,
  output logic [15:0] fetch_count
);

  localparam int unsigned W = 16;

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] instr_q, instr_d;
  logic [W-1:0] pcp2_q, pcp2_d;
  logic         valid_q, valid_d;
  logic         halt_q, halt_d;
  logic [W-1:0] cnt_q, cnt_d;

  logic         hold;
  logic         is_hlt;
  logic [W-1:0] pc_plus2;

  assign hold     = stall_mem | stall_br;
  assign is_hlt   = (imem_rdata[15:12] == HALT_OPCODE);
  assign pc_plus2 = pc_q + W'(2);

  // Next-state: hold > redirect > halted > miss > fetch
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp2_d  = pcp2_q;
    valid_d = valid_q;
    halt_d  = halt_q;
    cnt_d   = cnt_q;

    if (hold) begin
      // branch in ID is itself stalled, so everything freezes
    end else if (branch_taken) begin
      pc_d    = branch_target;
      state_d = RUN;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      halt_d  = 1'b0;
    end else if ((state_q == HALTED) || !imem_ready) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      halt_d  = 1'b0;
    end else begin
      instr_d = imem_rdata;
      pcp2_d  = pc_plus2;
      valid_d = 1'b1;
      halt_d  = is_hlt;
      cnt_d   = cnt_q + W'(1);
      if (is_hlt) begin
        state_d = HALTED;
      end else begin
        pc_d = pc_plus2;
      end
    end
  end

  // State and IF/ID registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pcp2_q  <= '0;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp2_q  <= pcp2_d;
      valid_q <= valid_d;
      halt_q  <= halt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr_FD    = instr_q;
  assign pcPlus2_FD  = pcp2_q;
  assign valid_FD    = valid_q;
  assign halt_FD     = halt_q;
  assign halted      = (state_q == HALTED);
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Bench for fetch_ifid_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_fetch_ifid_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_mem, stall_br, branch_taken, imem_ready;
  logic [15:0] branch_target, imem_rdata;
  logic [15:0] imem_addr, instr_FD, pcPlus2_FD, fetch_count;
  logic        valid_FD, halt_FD, halted;

  int checks = 0;
  int errors = 0;

  fetch_ifid_stage dut (
    .clk(clk), .rst(rst),
    .stall_mem(stall_mem), .stall_br(stall_br),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .imem_addr(imem_addr), .instr_FD(instr_FD), .pcPlus2_FD(pcPlus2_FD),
    .valid_FD(valid_FD), .halt_FD(halt_FD), .halted(halted),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Behavioural model of what the stage must hold after each edge
  logic [15:0] m_pc, m_instr, m_pcp2, m_cnt;
  logic        m_valid, m_halt, m_halted;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= 16'h0000; m_instr <= 16'h0000; m_pcp2 <= 16'h0000;
      m_cnt <= 16'h0000; m_valid <= 1'b0; m_halt <= 1'b0; m_halted <= 1'b0;
    end else if (!(stall_mem || stall_br)) begin
      if (branch_taken) begin
        m_pc <= branch_target; m_halted <= 1'b0;
        m_instr <= 16'h0000; m_valid <= 1'b0; m_halt <= 1'b0;
      end else if (m_halted || !imem_ready) begin
        m_instr <= 16'h0000; m_valid <= 1'b0; m_halt <= 1'b0;
      end else begin
        m_instr <= imem_rdata;
        m_pcp2  <= m_pc + 16'd2;
        m_valid <= 1'b1;
        m_cnt   <= m_cnt + 16'd1;
        m_halt  <= (imem_rdata[15:12] == 4'hF);
        if (imem_rdata[15:12] == 4'hF) m_halted <= 1'b1;
        else                           m_pc <= m_pc + 16'd2;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge
  always @(negedge clk) begin
    chk("m_imem_addr", imem_addr, m_pc);
    chk("m_instr_FD", instr_FD, m_instr);
    chk("m_pcPlus2_FD", pcPlus2_FD, m_pcp2);
    chk("m_valid_FD", 16'(valid_FD), 16'(m_valid));
    chk("m_halt_FD", 16'(halt_FD), 16'(m_halt));
    chk("m_halted", 16'(halted), 16'(m_halted));
    chk("m_fetch_count", fetch_count, m_cnt);
  end

  // Drive one cycle of inputs, then land 2 time units past the rising edge
  task automatic cyc(input logic sm, input logic sb, input logic bt,
                     input logic [15:0] tgt, input logic rdy, input logic [15:0] word);
    stall_mem = sm; stall_br = sb; branch_taken = bt; branch_target = tgt;
    imem_ready = rdy; imem_rdata = word;
    @(posedge clk); #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"}, imem_addr, 16'h0000);
    chk({tag, "_instr"}, instr_FD, 16'h0000);
    chk({tag, "_pcp2"}, pcPlus2_FD, 16'h0000);
    chk({tag, "_valid"}, 16'(valid_FD), 16'h0);
    chk({tag, "_halted"}, 16'(halted), 16'h0);
    chk({tag, "_cnt"}, fetch_count, 16'h0000);
  endtask

  initial begin
    rst = 1'b1;
    stall_mem = 0; stall_br = 0; branch_taken = 0; branch_target = 0;
    imem_ready = 0; imem_rdata = 0;
    @(posedge clk); #2;
    chk_reset_vals("rst0");
    rst = 1'b0;

    // Straight-line fetch
    cyc(0,0,0,16'h0,1,16'h1123);
    chk("t1_instr0", instr_FD, 16'h1123);
    cyc(0,0,0,16'h0,1,16'h2234);
    cyc(0,0,0,16'h0,1,16'h3345);
    chk("t1_pc", imem_addr, 16'h0006);
    chk("t1_instr", instr_FD, 16'h3345);
    chk("t1_pcp2", pcPlus2_FD, 16'h0006);
    chk("t1_cnt", fetch_count, 16'h0003);

    // Hazard holds, including a branch that must be ignored
    cyc(1,0,0,16'h0,1,16'h4456);
    cyc(1,0,0,16'h0,1,16'h4456);
    cyc(0,1,1,16'h0080,1,16'h4456);
    chk("t2_pc", imem_addr, 16'h0006);
    chk("t2_instr", instr_FD, 16'h3345);
    chk("t2_cnt", fetch_count, 16'h0003);
    cyc(0,0,0,16'h0,1,16'h4456);
    chk("t2_resume", pcPlus2_FD, 16'h0008);

    // Branch redirect
    cyc(0,0,1,16'h0040,1,16'h9999);
    chk("t3_pc", imem_addr, 16'h0040);
    chk("t3_valid", 16'(valid_FD), 16'h0);
    chk("t3_pcp2_kept", pcPlus2_FD, 16'h0008);
    cyc(0,0,0,16'h0,1,16'h5567);
    chk("t3_pcp2", pcPlus2_FD, 16'h0042);

    // Miss bubbles, then miss abandoned by a redirect
    cyc(0,0,1,16'h0010,1,16'h0);
    repeat (3) cyc(0,0,0,16'h0,0,16'hAAAA);
    chk("t4_pc", imem_addr, 16'h0010);
    chk("t4_valid", 16'(valid_FD), 16'h0);
    cyc(0,0,0,16'h0,1,16'h6678);
    chk("t4_instr", instr_FD, 16'h6678);
    cyc(0,0,0,16'h0,0,16'h0);
    cyc(0,0,1,16'h0020,0,16'h0);
    chk("t4_redir", imem_addr, 16'h0020);

    // HLT latched once, then frozen until a branch
    cyc(0,0,0,16'h0,1,16'hF000);
    chk("t5_instr", instr_FD, 16'hF000);
    chk("t5_halt", 16'(halt_FD), 16'h1);
    chk("t5_halted", 16'(halted), 16'h1);
    cyc(0,0,0,16'h0,1,16'h7789);
    chk("t5_pc", imem_addr, 16'h0020);
    chk("t5_bubble", 16'(halt_FD), 16'h0);
    cyc(0,0,1,16'h0030,1,16'h7789);
    chk("t5_wake_pc", imem_addr, 16'h0030);
    chk("t5_wake", 16'(halted), 16'h0);
    cyc(0,0,1,16'h0050,1,16'hF123);
    chk("t5_same_pc", imem_addr, 16'h0050);
    chk("t5_same_halted", 16'(halted), 16'h0);

    // Asynchronous reset mid-hold and mid-halt
    cyc(1,0,0,16'h0,1,16'h1234);
    rst = 1'b1; #1;
    chk_reset_vals("t6a");
    rst = 1'b0;
    cyc(0,0,0,16'h0,1,16'h1111);
    cyc(0,0,0,16'h0,1,16'hF000);
    cyc(0,0,0,16'h0,1,16'h2222);
    chk("t6_halted", 16'(halted), 16'h1);
    rst = 1'b1; #1;
    chk_reset_vals("t6b");
    rst = 1'b0;

    // PC wrap
    cyc(0,0,1,16'hFFFE,1,16'h0);
    cyc(0,0,0,16'h0,1,16'h1111);
    chk("t6_wrap_pc", imem_addr, 16'h0000);
    chk("t6_wrap_pcp2", pcPlus2_FD, 16'h0000);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 9) == 0) w[15:12] = 4'hF;
      else if (w[15:12] == 4'hF)    w[15:12] = 4'h1;
      cyc(($urandom_range(0,5) == 0), ($urandom_range(0,5) == 0),
          ($urandom_range(0,7) == 0), 16'($urandom) & 16'hFFFE,
          ($urandom_range(0,3) != 0), w);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1; #1;
        rst = 1'b0;
      end
    end

    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
